// File: rtl/cpu_pad_bus_mux.sv
// Time-multiplexed CPU-to-pad bus bridge: MSB-first address beats, one data phase, wait/timeout.
// Optional feature: define TURNAROUND_EN to add a one-cycle pad turnaround after every read.
module cpu_pad_bus_mux #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 8,
  parameter int PAD_W    = 8,
  parameter int WAIT_MAX = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_valid,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic              cpu_err,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic [PAD_W-1:0]  pad_in,
  output logic [PAD_W-1:0]  pad_out,
  output logic [PAD_W-1:0]  pad_oeb,
  output logic              pad_ale,
  output logic              pad_first,
  output logic              pad_we,
  input  logic              ext_wait
);

  localparam int N_BEATS = (ADDR_W + PAD_W - 1) / PAD_W;
  localparam int AW_PAD  = N_BEATS * PAD_W;
  localparam int BEAT_W  = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
  localparam int WAIT_W  = $clog2(WAIT_MAX + 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(N_BEATS - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_MAX);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_DONE,
    S_TURN
  } state_t;

  state_t              state;
  logic [BEAT_W-1:0]   beat;
  logic [WAIT_W-1:0]   wait_cnt;
  logic                we_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [AW_PAD-1:0]   addr_sh;
  logic [AW_PAD-1:0]   addr_pad;

  assign addr_pad = AW_PAD'(cpu_addr);

  // Outputs are computed for the state being entered, so every pad/CPU output is a flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      beat      <= '0;
      wait_cnt  <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      addr_sh   <= '0;
      pad_out   <= '0;
      pad_oeb   <= '1;
      pad_ale   <= 1'b0;
      pad_first <= 1'b0;
      pad_we    <= 1'b0;
      cpu_ready <= 1'b0;
      cpu_err   <= 1'b0;
      cpu_rdata <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cpu_valid) begin
            state     <= S_ADDR;
            beat      <= '0;
            we_q      <= cpu_we;
            wdata_q   <= cpu_wdata;
            addr_sh   <= addr_pad << PAD_W;
            pad_out   <= addr_pad[AW_PAD-1 -: PAD_W];
            pad_oeb   <= '0;
            pad_ale   <= 1'b1;
            pad_first <= 1'b1;
          end
        end

        S_ADDR: begin
          pad_first <= 1'b0;
          if (beat == LAST_BEAT) begin
            state    <= S_DATA;
            wait_cnt <= '0;
            pad_ale  <= 1'b0;
            if (we_q) begin
              pad_out <= PAD_W'(wdata_q);
              pad_oeb <= '0;
              pad_we  <= 1'b1;
            end else begin
              pad_out <= '0;
              pad_oeb <= '1;
              pad_we  <= 1'b0;
            end
          end else begin
            beat    <= beat + 1'b1;
            pad_out <= addr_sh[AW_PAD-1 -: PAD_W];
            addr_sh <= addr_sh << PAD_W;
          end
        end

        // Still waiting on the last allowed cycle means timeout; reads then return all ones.
        S_DATA: begin
          if (!ext_wait || wait_cnt == WAIT_LAST) begin
            state     <= S_DONE;
            cpu_ready <= 1'b1;
            cpu_err   <= ext_wait;
            if (!we_q) begin
              cpu_rdata <= ext_wait ? '1 : pad_in[DATA_W-1:0];
            end
            pad_out <= '0;
            pad_oeb <= '1;
            pad_we  <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        S_DONE: begin
          cpu_ready <= 1'b0;
          cpu_err   <= 1'b0;
`ifdef TURNAROUND_EN
          state <= we_q ? S_IDLE : S_TURN;
`else
          state <= S_IDLE;
`endif
        end

        S_TURN: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_pad_bus_mux.sv
// Bench for cpu_pad_bus_mux: default instance (16-bit address) and a 20-bit/WAIT_MAX=4 instance,
// checked cycle by cycle against a transaction-level timing model.
module tb_cpu_pad_bus_mux;

`ifdef TURNAROUND_EN
  localparam bit TURN_EN = 1'b1;
`else
  localparam bit TURN_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        a_valid, b_valid;
  logic        cpu_we;
  logic [19:0] tb_addr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  pad_in;
  logic        ext_wait;

  logic       a_ready, a_err, a_ale, a_first, a_we;
  logic [7:0] a_rdata, a_out, a_oeb;
  logic       b_ready, b_err, b_ale, b_first, b_we;
  logic [7:0] b_rdata, b_out, b_oeb;

  always #5 clk = ~clk;

  cpu_pad_bus_mux dut_a (
    .clk(clk), .reset(reset), .cpu_valid(a_valid), .cpu_we(cpu_we),
    .cpu_addr(tb_addr[15:0]), .cpu_wdata(cpu_wdata), .cpu_ready(a_ready),
    .cpu_err(a_err), .cpu_rdata(a_rdata), .pad_in(pad_in), .pad_out(a_out),
    .pad_oeb(a_oeb), .pad_ale(a_ale), .pad_first(a_first), .pad_we(a_we),
    .ext_wait(ext_wait)
  );

  cpu_pad_bus_mux #(.ADDR_W(20), .DATA_W(8), .PAD_W(8), .WAIT_MAX(4)) dut_b (
    .clk(clk), .reset(reset), .cpu_valid(b_valid), .cpu_we(cpu_we),
    .cpu_addr(tb_addr), .cpu_wdata(cpu_wdata), .cpu_ready(b_ready),
    .cpu_err(b_err), .cpu_rdata(b_rdata), .pad_in(pad_in), .pad_out(b_out),
    .pad_oeb(b_oeb), .pad_ale(b_ale), .pad_first(b_first), .pad_we(b_we),
    .ext_wait(ext_wait)
  );

  typedef struct packed {
    logic       ready;
    logic       err;
    logic [7:0] rdata;
    logic [7:0] out;
    logic [7:0] oeb;
    logic       ale;
    logic       first;
    logic       we;
  } obs_t;

  typedef struct {
    int         sel;
    bit         we;
    logic [19:0] addr;
    logic [7:0] wd;
    int         waits;
    logic [7:0] rv;
    bit         hold;
    int         exp_ready;
    bit         exp_err;
    logic [7:0] exp_rdata;
  } txn_t;

  int errors = 0;
  int checks = 0;
  logic [7:0] model_rdata [2];

  function automatic obs_t getObs(input int sel);
    obs_t o;
    if (sel == 1) o = '{ready: b_ready, err: b_err, rdata: b_rdata, out: b_out, oeb: b_oeb,
                        ale: b_ale, first: b_first, we: b_we};
    else          o = '{ready: a_ready, err: a_err, rdata: a_rdata, out: a_out, oeb: a_oeb,
                        ale: a_ale, first: a_first, we: a_we};
    return o;
  endfunction

  function automatic obs_t idleObs(input logic [7:0] rdata);
    obs_t e;
    e = '{ready: 1'b0, err: 1'b0, rdata: rdata, out: 8'h00, oeb: 8'hFF,
          ale: 1'b0, first: 1'b0, we: 1'b0};
    return e;
  endfunction

  task automatic checkOutput(input string name, input int cyc, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic checkCycle(input int sel, input int cyc, input obs_t e, input string tag);
    obs_t o;
    o = getObs(sel);
    checkOutput({tag, ".cpu_ready"}, cyc, 32'(o.ready), 32'(e.ready));
    checkOutput({tag, ".cpu_err"},   cyc, 32'(o.err),   32'(e.err));
    checkOutput({tag, ".cpu_rdata"}, cyc, 32'(o.rdata), 32'(e.rdata));
    checkOutput({tag, ".pad_out"},   cyc, 32'(o.out),   32'(e.out));
    checkOutput({tag, ".pad_oeb"},   cyc, 32'(o.oeb),   32'(e.oeb));
    checkOutput({tag, ".pad_ale"},   cyc, 32'(o.ale),   32'(e.ale));
    checkOutput({tag, ".pad_first"}, cyc, 32'(o.first), 32'(e.first));
    checkOutput({tag, ".pad_we"},    cyc, 32'(o.we),    32'(e.we));
  endtask

  // One full access: request at cycle 0, then every cycle up to the idle after completion is checked.
  task automatic applyStimulus(input int sel, input bit we, input logic [19:0] addr,
                               input logic [7:0] wd, input int waits, input logic [7:0] rv,
                               input bit hold, output int ready_cyc, output logic rerr,
                               output logic [7:0] rrdata);
    int   n, wm, d, rc, last, di;
    bit   tmo;
    obs_t e;
    n    = (sel == 1) ? 3 : 2;
    wm   = (sel == 1) ? 4 : 15;
    tmo  = (waits > wm);
    d    = tmo ? wm + 1 : waits + 1;
    rc   = n + 1 + d;
    last = rc + 1 + ((TURN_EN && !we) ? 1 : 0);
    ready_cyc = -1;
    rerr      = 1'b0;
    rrdata    = 8'h00;
    @(negedge clk);
    if (sel == 1) b_valid = 1'b1; else a_valid = 1'b1;
    cpu_we    = we;
    tb_addr   = addr;
    cpu_wdata = wd;
    ext_wait  = 1'($urandom);
    pad_in    = 8'($urandom);
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      e = idleObs(model_rdata[sel]);
      if (c <= n) begin
        e.out   = 8'((int'(addr) >> (8 * (n - c))) & 255);
        e.oeb   = 8'h00;
        e.ale   = 1'b1;
        e.first = (c == 1);
      end else if (c <= n + d) begin
        if (we) begin
          e.out = wd;
          e.oeb = 8'h00;
          e.we  = 1'b1;
        end
      end else if (c == rc) begin
        e.ready = 1'b1;
        e.err   = tmo;
        if (!we) model_rdata[sel] = tmo ? 8'hFF : rv;
        e.rdata = model_rdata[sel];
      end
      checkCycle(sel, c, e, (sel == 1) ? "b" : "a");
      if (getObs(sel).ready && ready_cyc < 0) begin
        ready_cyc = c;
        rerr      = getObs(sel).err;
        rrdata    = getObs(sel).rdata;
      end
      if (sel == 1) b_valid = hold && (c < rc); else a_valid = hold && (c < rc);
      tb_addr   = 20'($urandom);
      cpu_wdata = 8'($urandom);
      cpu_we    = 1'($urandom);
      di = c - n;
      if (c > n && c <= n + d) begin
        ext_wait = (di <= waits);
        pad_in   = (di == waits + 1) ? rv : 8'($urandom);
      end else begin
        ext_wait = 1'($urandom);
        pad_in   = 8'($urandom);
      end
    end
  endtask

  txn_t tbl [7];

  initial begin
    int         rc;
    logic       rerr;
    logic [7:0] rrd;
    int         bcyc;
    obs_t       o;

    tbl[0] = '{sel: 0, we: 1'b1, addr: 20'h0BEEF, wd: 8'h5A, waits: 0,  rv: 8'h00, hold: 1'b0,
               exp_ready: 4,  exp_err: 1'b0, exp_rdata: 8'h00};
    tbl[1] = '{sel: 0, we: 1'b0, addr: 20'h01234, wd: 8'h00, waits: 3,  rv: 8'hC3, hold: 1'b1,
               exp_ready: 7,  exp_err: 1'b0, exp_rdata: 8'hC3};
    tbl[2] = '{sel: 1, we: 1'b0, addr: 20'h00123, wd: 8'h00, waits: 9,  rv: 8'h55, hold: 1'b0,
               exp_ready: 9,  exp_err: 1'b1, exp_rdata: 8'hFF};
    tbl[3] = '{sel: 1, we: 1'b1, addr: 20'hABCDE, wd: 8'h77, waits: 0,  rv: 8'h00, hold: 1'b1,
               exp_ready: 5,  exp_err: 1'b0, exp_rdata: 8'hFF};
    tbl[4] = '{sel: 0, we: 1'b1, addr: 20'h00000, wd: 8'hFF, waits: 15, rv: 8'h00, hold: 1'b0,
               exp_ready: 19, exp_err: 1'b0, exp_rdata: 8'hC3};
    tbl[5] = '{sel: 0, we: 1'b0, addr: 20'h0FFFF, wd: 8'h00, waits: 16, rv: 8'h11, hold: 1'b0,
               exp_ready: 19, exp_err: 1'b1, exp_rdata: 8'hFF};
    tbl[6] = '{sel: 1, we: 1'b0, addr: 20'hFFFFF, wd: 8'h00, waits: 4,  rv: 8'h3C, hold: 1'b0,
               exp_ready: 9,  exp_err: 1'b0, exp_rdata: 8'h3C};

    reset = 1'b1; a_valid = 1'b0; b_valid = 1'b0; cpu_we = 1'b0;
    tb_addr = '0; cpu_wdata = '0; pad_in = '0; ext_wait = 1'b0;
    model_rdata[0] = 8'h00;
    model_rdata[1] = 8'h00;
    repeat (2) @(negedge clk);
    checkCycle(0, 0, idleObs(8'h00), "reset_a");
    checkCycle(1, 0, idleObs(8'h00), "reset_b");
    reset = 1'b0;

    // Reset asserted during ADDR beat 1 of a write must clear outputs without waiting for a clock.
    @(negedge clk);
    a_valid = 1'b1; cpu_we = 1'b1; tb_addr = 20'h0BEEF; cpu_wdata = 8'h5A;
    @(negedge clk);
    a_valid = 1'b0;
    @(negedge clk);
    o = getObs(0);
    checkOutput("midreset.beat1_ale", 2, 32'(o.ale), 32'(1'b1));
    reset = 1'b1;
    #1;
    checkCycle(0, 2, idleObs(8'h00), "midreset");
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checkCycle(0, c, idleObs(8'h00), "postreset");
    end

    for (int i = 0; i < 7; i++) begin
      applyStimulus(tbl[i].sel, tbl[i].we, tbl[i].addr, tbl[i].wd, tbl[i].waits, tbl[i].rv,
                    tbl[i].hold, rc, rerr, rrd);
      checkOutput($sformatf("tbl%0d.ready_cycle", i), rc, 32'(rc), 32'(tbl[i].exp_ready));
      checkOutput($sformatf("tbl%0d.err", i), rc, 32'(rerr), 32'(tbl[i].exp_err));
      checkOutput($sformatf("tbl%0d.rdata", i), rc, 32'(rrd), 32'(tbl[i].exp_rdata));
    end

    // Back-to-back with cpu_valid held: the request seen during DONE must not be taken.
    bcyc = TURN_EN ? 7 : 6;
    @(negedge clk);
    a_valid = 1'b1; cpu_we = 1'b0; tb_addr = 20'h04321; cpu_wdata = 8'h00;
    ext_wait = 1'b0; pad_in = 8'h96;
    for (int c = 1; c <= bcyc + 4; c++) begin
      @(negedge clk);
      o = getObs(0);
      if (c == 4) begin
        checkOutput("b2b.read_ready", c, 32'(o.ready), 32'(1'b1));
        checkOutput("b2b.read_rdata", c, 32'(o.rdata), 32'(8'h96));
        cpu_we = 1'b1; tb_addr = 20'h08765; cpu_wdata = 8'hA5;
      end
      if (c == bcyc - 1) begin
        checkOutput("b2b.gap_ale", c, 32'(o.ale), 32'(1'b0));
        checkOutput("b2b.gap_oeb", c, 32'(o.oeb), 32'(8'hFF));
      end
      if (c == bcyc) begin
        checkOutput("b2b.beat0_ale", c, 32'(o.ale), 32'(1'b1));
        checkOutput("b2b.beat0_first", c, 32'(o.first), 32'(1'b1));
        checkOutput("b2b.beat0_out", c, 32'(o.out), 32'(8'h87));
        a_valid = 1'b0;
      end
      if (c == bcyc + 2) checkOutput("b2b.wr_data", c, 32'(o.out), 32'(8'hA5));
      if (c == bcyc + 3) begin
        checkOutput("b2b.wr_ready", c, 32'(o.ready), 32'(1'b1));
        checkOutput("b2b.wr_rdata", c, 32'(o.rdata), 32'(8'h96));
      end
      if (c == bcyc + 4) checkOutput("b2b.idle_ready", c, 32'(o.ready), 32'(1'b0));
    end
    model_rdata[0] = 8'h96;

    for (int i = 0; i < 30; i++) begin
      int sel, wm;
      sel = int'($urandom_range(1, 0));
      wm  = (sel == 1) ? 4 : 15;
      applyStimulus(sel, 1'($urandom), (sel == 1) ? 20'($urandom) : {4'h0, 16'($urandom)},
                    8'($urandom), int'($urandom_range(wm + 2, 0)), 8'($urandom),
                    1'($urandom), rc, rerr, rrd);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule

// File: doc/cpu_pad_bus_mux.md
# cpu_pad_bus_mux

Parametrised external-bus bridge between the CPU core and the user IO pads. It time-multiplexes the CPU address and data buses onto a shared group of `PAD_W` bidirectional pads: address beats come first, followed by one data phase. It supports external wait-states with a timeout. It replaces the fixed one-pin-per-bit mapping and lets wide-address cores fit into the pad budget.

## Interface
Parameters:
- `ADDR_W`, default 16: CPU address width.
- `DATA_W`, default 8: CPU data width; must be ≤ `PAD_W`.
- `PAD_W`, default 8: shared address/data pad count.
- `WAIT_MAX`, default 15: maximum wait cycles in the data phase before timeout; must be ≥ 1.

Ports:
- `clk`, in, 1: single clock; all logic is rising-edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `cpu_valid`, in, 1: access request.
- `cpu_we`, in, 1: 1 = write, 0 = read.
- `cpu_addr`, in, `ADDR_W`: access address.
- `cpu_wdata`, in, `DATA_W`: write data.
- `cpu_ready`, out, 1: one-cycle completion pulse.
- `cpu_err`, out, 1: timeout flag; valid with `cpu_ready`.
- `cpu_rdata`, out, `DATA_W`: read data; valid with `cpu_ready` and held until the next completion.
- `pad_in`, in, `PAD_W`: pad input values.
- `pad_out`, out, `PAD_W`: pad drive values.
- `pad_oeb`, out, `PAD_W`: per-pad output-enable bar; 1 = pad is an input.
- `pad_ale`, out, 1: address latch enable; high during address beats.
- `pad_first`, out, 1: high on address beat 0 only.
- `pad_we`, out, 1: high during a write data phase.
- `ext_wait`, in, 1: external wait request; sampled during the data phase.

## Operation
- N = ceil(`ADDR_W`/`PAD_W`) address beats.
- States: IDLE → ADDR (N cycles, beat counter 0..N-1) → DATA (≥1 cycle) → DONE (1 cycle) → IDLE.
- When `TURNAROUND_EN` is defined, a read's DONE goes to TURN (1 cycle) before IDLE.
- IDLE: samples `cpu_valid`. If high, the block captures `cpu_addr`, `cpu_wdata` and `cpu_we` into internal registers and moves to ADDR.
  - Later changes on the CPU inputs, including `cpu_valid` dropping, do not affect the transaction in flight.
- ADDR beat k:
  - `pad_out` carries address chunk k, MSB-first. Beat 0 carries the top bits, zero-extended when `ADDR_W` is not a multiple of `PAD_W`.
  - `pad_oeb` = 0, `pad_ale` = 1, `pad_first` = (k == 0).
- DATA, write: `pad_out` = captured wdata zero-extended to `PAD_W`; `pad_oeb` = 0; `pad_we` = 1.
- DATA, read: `pad_oeb` = all 1; `pad_out` = 0; `pad_we` = 0.
- DATA exit:
  - Exits to DONE on the first DATA cycle with `ext_wait` = 0. For a read, `pad_in[DATA_W-1:0]` is captured into `cpu_rdata` at that edge.
  - A wait counter counts DATA cycles. If `ext_wait` is still 1 on DATA cycle `WAIT_MAX`+1, the block exits to DONE with the error set, and `cpu_rdata` = all ones on a read.
- DONE: `cpu_ready` = 1 for exactly one cycle; `cpu_err` = 1 only after a timeout. Pads are released (`pad_oeb` = all 1) in DONE, TURN and IDLE.
- A request is never accepted in DONE. Back-to-back requests therefore need `cpu_valid` held through the IDLE cycle.

## Timing
- All outputs are registered.
- Reset values: state IDLE, `pad_oeb` all 1, `pad_out` 0, `pad_ale`/`pad_first`/`pad_we` 0, `cpu_ready` 0, `cpu_err` 0, `cpu_rdata` 0.
- Latency, with `cpu_valid` sampled at cycle 0 and no waits:
  - Address beats at cycles 1..N, DATA at N+1, `cpu_ready` at N+2.
  - Next acceptance is at IDLE cycle N+3, or N+4 after a read when `TURNAROUND_EN` is defined.
- With W wait cycles, `cpu_ready` is at N+2+W, where W ≤ `WAIT_MAX`.
- Reset asserted mid-transaction: all outputs return to reset values immediately (asynchronously). No completion pulse is issued and the access is lost.
- `ext_wait` is ignored outside DATA.

## Configuration
- `TURNAROUND_EN` defined: after every read, one TURN cycle with pads released, `pad_ale`/`pad_we` low and requests ignored. This prevents pad drive fights with slow external devices.
- `TURNAROUND_EN` undefined: DONE returns directly to IDLE for reads and writes alike.

## Test plan
- Reset values: hold `reset` high mid-write (in ADDR beat 1) → all outputs at reset values that same cycle, `pad_oeb` = 8'hFF; after release, IDLE with no spurious `cpu_ready`.
- Write, defaults: `cpu_addr` = 16'hBEEF, `cpu_wdata` = 8'h5A, `ext_wait` = 0 →
  - cycle 1: `pad_out` = 8'hBE, `pad_ale` = 1, `pad_first` = 1;
  - cycle 2: `pad_out` = 8'hEF, `pad_first` = 0;
  - cycle 3: `pad_out` = 8'h5A, `pad_we` = 1;
  - cycle 4: `cpu_ready` = 1, `cpu_err` = 0.
- Read with waits: `cpu_addr` = 16'h1234, `ext_wait` high for 3 DATA cycles, `pad_in` = 8'hC3 when it drops → `pad_oeb` = 8'hFF in DATA, `cpu_ready` at cycle 7, `cpu_rdata` = 8'hC3.
- Timeout: `WAIT_MAX` = 4, `ext_wait` held high on a read → DATA lasts 5 cycles, then `cpu_ready` = 1, `cpu_err` = 1, `cpu_rdata` = 8'hFF.
- Odd width: `ADDR_W` = 20, `PAD_W` = 8, addr 20'hABCDE → beats 8'h0A, 8'hBC, 8'hDE, `cpu_ready` at cycle 5.
- Back-to-back with `cpu_valid` held high: read then write → second beat 0 at cycle 6 when `TURNAROUND_EN` is undefined, cycle 7 when defined. `cpu_valid` dropping during ADDR → transaction still completes.
